// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl_if
// Brief   : Hazard inputs and stall/flush enables between the pipeline
//           datapath (master) and the hazard controller (slave).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        imem_ready;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic [1:0]  state;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, imem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, state,
               stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, imem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, state,
               stall_count, flush_count
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Stall/flush controller driving PC, IF/ID and ID/EX enables.
//           Define HAZARD_PERF_EN to build the stall/flush perf counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl (
    input  wire                     clk,
    input  wire                     reset,
    pipeline_hazard_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN           = 2'd0,
        IMEM_WAIT     = 2'd1,
        REDIRECT_WAIT = 2'd2,
        ILLEGAL       = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_load_use;
    logic   w_pc_write;
    logic   w_if_id_write;
    logic   w_if_id_flush;
    logic   w_id_ex_bubble;

    assign w_load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                        ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                         (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_next_state   = RUN;
        if (reset) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else begin
            case (r_state)
                REDIRECT_WAIT: begin
                    // Wrong-path fetch still in flight; flush whatever returns.
                    w_pc_write     = 1'b0;
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                    w_next_state   = bus.imem_ready ? RUN : REDIRECT_WAIT;
                end
                default: begin
                    if (bus.ex_branch_taken) begin
                        w_if_id_flush  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                        w_next_state   = bus.imem_ready ? RUN : REDIRECT_WAIT;
                    end else if (w_load_use) begin
                        w_pc_write     = 1'b0;
                        w_if_id_write  = 1'b0;
                        w_id_ex_bubble = 1'b1;
                        w_next_state   = bus.imem_ready ? RUN : IMEM_WAIT;
                    end else if (!bus.imem_ready) begin
                        w_pc_write     = 1'b0;
                        w_if_id_flush  = 1'b1;
                        w_next_state   = IMEM_WAIT;
                    end
                    if (r_state == ILLEGAL) begin
                        w_next_state = RUN;
                    end
                end
            endcase
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_bubble = w_id_ex_bubble;
    assign bus.state        = r_state;

`ifdef HAZARD_PERF_EN
    logic        w_branch_accept;
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    assign w_branch_accept = !reset && (r_state != REDIRECT_WAIT) && bus.ex_branch_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (!w_pc_write) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (w_branch_accept) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign bus.stall_count = r_stall_count;
    assign bus.flush_count = r_flush_count;
`else
    assign bus.stall_count = 32'd0;
    assign bus.flush_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RV64 pipeline. Each cycle it decides whether the PC advances, whether the IF/ID register captures, holds or loads a NOP, and whether the ID/EX register receives a bubble. Inputs are load-use hazards from ID/EX, taken branches resolved in EX, and instruction-memory readiness. It sits beside the IF/ID and ID/EX registers and drives their enables.

## Interface
- No parameters.
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_branch_taken  in  1  the branch or jump in EX redirects the PC this cycle.
- imem_ready  in  1  the instruction word at the IF stage is valid this cycle.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF/ID capture enable; 0 holds the register.
- if_id_flush  out  1  IF/ID loads NOP (32'h00000013) and PC 0; overrides if_id_write.
- id_ex_bubble  out  1  ID/EX loads all-zero control signals.
- state  out  2  current FSM state.
- stall_count  out  32  cycles with pc_write=0 (see Configuration).
- flush_count  out  32  taken redirects (see Configuration).

## Operation
- Load-use detection: load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- FSM states: RUN=2'd0, IMEM_WAIT=2'd1, REDIRECT_WAIT=2'd2. State 2'd3 is illegal and goes to RUN on the next edge, with outputs as in RUN.
- RUN and IMEM_WAIT share the output rules below, applied in priority order:
  1. ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1. Next state is REDIRECT_WAIT if imem_ready=0, else RUN.
  2. load_use: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1. Next state is IMEM_WAIT if imem_ready=0, else RUN.
  3. !imem_ready: pc_write=0, if_id_write=1, if_id_flush=1, id_ex_bubble=0. Next state is IMEM_WAIT.
  4. Otherwise: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0. Next state is RUN.
- REDIRECT_WAIT exists because the fetch in flight when the redirect happened is wrong-path:
  - Outputs: pc_write=0, if_id_write=1, if_id_flush=1, id_ex_bubble=1. ex_branch_taken and load_use are ignored here; ID and EX already hold bubbles.
  - On imem_ready=1 the returned word is discarded through the flush and the next state is RUN.
  - Otherwise the FSM stays in REDIRECT_WAIT.
- Control outputs are combinational from state and inputs. State and counters are registered.

## Timing
- Reset, asynchronous: state=RUN, counters=0.
- While reset is asserted the outputs are forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1. The first normal decision is made in the first cycle after deassertion.
- Latency: a hazard seen in cycle N gates the edge that ends cycle N. No pipeline delay exists inside the block.
- A load-use hazard costs exactly 1 stall cycle when imem_ready=1.
- A taken branch costs 2 flushed slots (IF/ID and ID/EX), plus 1 extra cycle per cycle spent in REDIRECT_WAIT.
- Simultaneous branch and load-use: the branch wins, because the hazarding ID instruction is wrong-path.
- Simultaneous load-use and !imem_ready: IF/ID holds (rule 2), so the ID instruction is not lost.
- Reset asserted mid-REDIRECT_WAIT or mid-stall: the FSM returns to RUN immediately and no completion is required.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_count increments on every non-reset cycle with pc_write=0.
  - flush_count increments on every cycle where ex_branch_taken is accepted, i.e. rule 1 in RUN or IMEM_WAIT.
  - Both wrap modulo 2^32 and clear on reset.
- HAZARD_PERF_EN undefined: the counter registers are not built and both ports are driven to constant 0. All other behaviour is identical.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, imem_ready=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 for 1 cycle, then all-pass. stall_count=1.
- ex_rd=0 with a matching rs1 and a load -> no stall. id_uses_rs2=0 with id_rs2==ex_rd -> no stall.
- Taken branch with imem_ready=0, then imem_ready=1 after 3 cycles -> if_id_flush=1 for 4 cycles, state sequence RUN→REDIRECT_WAIT(×3)→RUN, flush_count=1, stall_count=3.
- imem_ready=0 for 2 cycles in RUN -> pc_write=0 and if_id_flush=1 for 2 cycles, state=IMEM_WAIT, then RUN with pc_write=1.
- Branch and load-use in the same cycle -> rule-1 outputs only, no hold.
- Assert reset while in REDIRECT_WAIT -> state=0 and counters=0 immediately, with the reset output values. Checked with and without HAZARD_PERF_EN (counters stay 0 without it).
